// File: rtl/dispense_ctrl.sv
// Alcohol dispenser sequencer: qualifies a hand for one timer second, runs the
// pump for DISP_SEC seconds, cools down, then waits for the hand to leave.
//   state      | meaning
//   S_IDLE     | timer stopped, waiting for hand with liquid available
//   S_DETECT   | one-second hand qualification
//   S_DISPENSE | pump on, counting dose seconds
//   S_COOL     | pump off, counting cooldown seconds
//   S_RELEASE  | waiting for the hand to be withdrawn
module dispense_ctrl #(
  parameter int DISP_SEC = 3,
  parameter int COOL_SEC = 2,
  parameter int SEC_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hand_det,
  input  logic             level_ok,
  input  logic             count_ack,
  output logic             count_req,
  output logic             pump_en,
  output logic             busy,
  output logic             empty_alarm,
  output logic             dose_done,
  output logic [SEC_W-1:0] sec_left
);

  typedef enum logic [2:0] {
    S_IDLE, S_DETECT, S_DISPENSE, S_COOL, S_RELEASE
  } state_t;

  state_t             state_q, state_d;
  logic               count_req_q, count_req_d;
  logic               pump_en_q, pump_en_d;
  logic               busy_q, busy_d;
  logic               empty_alarm_q, empty_alarm_d;
  logic               dose_done_q, dose_done_d;
  logic [SEC_W-1:0]   sec_left_q, sec_left_d;
  logic               ack_ok;
  logic               timed_d;

  // count_req_q is only high after the first cycle of a timed state
  assign ack_ok = count_ack & count_req_q;

  always_comb begin
    state_d       = state_q;
    empty_alarm_d = empty_alarm_q;
    sec_left_d    = sec_left_q;
    dose_done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (level_ok && !hand_det) empty_alarm_d = 1'b0;
        if (hand_det && level_ok && !empty_alarm_q) state_d = S_DETECT;
      end
      S_DETECT: begin
        if (!hand_det) begin
          state_d = S_IDLE;
        end else if (!level_ok) begin
          empty_alarm_d = 1'b1;
          state_d       = S_IDLE;
        end else if (ack_ok) begin
          state_d    = S_DISPENSE;
          sec_left_d = SEC_W'(DISP_SEC);
        end
      end
      S_DISPENSE: begin
        if (!level_ok) begin
          empty_alarm_d = 1'b1;
          state_d       = S_COOL;
          sec_left_d    = SEC_W'(COOL_SEC);
        end else if (ack_ok) begin
          if (sec_left_q == SEC_W'(1)) begin
            state_d     = S_COOL;
            sec_left_d  = SEC_W'(COOL_SEC);
            dose_done_d = 1'b1;
          end else begin
            sec_left_d = sec_left_q - SEC_W'(1);
          end
        end
      end
      S_COOL: begin
        if (ack_ok) begin
          if (sec_left_q == SEC_W'(1)) begin
            state_d    = S_RELEASE;
            sec_left_d = '0;
          end else begin
            sec_left_d = sec_left_q - SEC_W'(1);
          end
        end
      end
      S_RELEASE: begin
        if (!hand_det) state_d = S_IDLE;
      end
      default: begin
        state_d    = S_IDLE;
        sec_left_d = '0;
      end
    endcase

    // Dropping the request on entry clears the timer so each phase gets full seconds
    timed_d     = (state_d == S_DETECT) || (state_d == S_DISPENSE) || (state_d == S_COOL);
    count_req_d = timed_d && (state_d == state_q);
    pump_en_d   = (state_d == S_DISPENSE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      count_req_q   <= 1'b0;
      pump_en_q     <= 1'b0;
      busy_q        <= 1'b0;
      empty_alarm_q <= 1'b0;
      dose_done_q   <= 1'b0;
      sec_left_q    <= '0;
    end else begin
      state_q       <= state_d;
      count_req_q   <= count_req_d;
      pump_en_q     <= pump_en_d;
      busy_q        <= busy_d;
      empty_alarm_q <= empty_alarm_d;
      dose_done_q   <= dose_done_d;
      sec_left_q    <= sec_left_d;
    end
  end

  assign count_req   = count_req_q;
  assign pump_en     = pump_en_q;
  assign busy        = busy_q;
  assign empty_alarm = empty_alarm_q;
  assign dose_done   = dose_done_q;
  assign sec_left    = sec_left_q;

endmodule

// File: tb/tb_dispense_ctrl.sv
// Bench for dispense_ctrl: behavioural timer (CNT=10), phase/ack-count model
// compared every cycle, plus literal phase-length checks for each scenario.
module tb_dispense_ctrl;
  localparam int DISP_SEC = 3;
  localparam int COOL_SEC = 2;
  localparam int SEC_W    = 4;
  localparam int CNT      = 10;

  localparam int P_IDLE = 0, P_DET = 1, P_DISP = 2, P_COOL = 3, P_REL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hand_det = 1'b0;
  logic level_ok = 1'b1;
  logic count_ack;
  logic count_req, pump_en, busy, empty_alarm, dose_done;
  logic [SEC_W-1:0] sec_left;
  logic [7:0] tcnt;

  int errors = 0;
  int checks = 0;

  dispense_ctrl #(.DISP_SEC(DISP_SEC), .COOL_SEC(COOL_SEC), .SEC_W(SEC_W)) dut (
    .clk(clk), .rst_n(rst_n), .hand_det(hand_det), .level_ok(level_ok),
    .count_ack(count_ack), .count_req(count_req), .pump_en(pump_en),
    .busy(busy), .empty_alarm(empty_alarm), .dose_done(dose_done),
    .sec_left(sec_left)
  );

  always #5 clk = ~clk;

  // one-second timer: counts 0..CNT while requested, ack on the CNT cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt <= '0;
    else if (!count_req || tcnt == 8'(CNT)) tcnt <= '0;
    else tcnt <= tcnt + 8'd1;
  end
  assign count_ack = count_req && (tcnt == 8'(CNT));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: phase, cycles spent in it, and accepted seconds within it
  int  m_ph = P_IDLE, m_age = 0, m_acks = 0;
  bit  m_alarm = 0, m_done = 0;

  function automatic bit m_timed(input int ph);
    return ph == P_DET || ph == P_DISP || ph == P_COOL;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_ph = P_IDLE; m_age = 0; m_acks = 0; m_alarm = 0; m_done = 0;
    end else begin
      automatic int  nph = m_ph;
      automatic bit  acc = count_ack && m_timed(m_ph) && m_age > 0;
      m_done = 0;
      case (m_ph)
        P_IDLE: begin
          if (level_ok && !hand_det) m_alarm = 0;
          if (hand_det && level_ok && !m_alarm) nph = P_DET;
        end
        P_DET: begin
          if (!hand_det) nph = P_IDLE;
          else if (!level_ok) begin m_alarm = 1; nph = P_IDLE; end
          else if (acc) nph = P_DISP;
        end
        P_DISP: begin
          if (!level_ok) begin m_alarm = 1; nph = P_COOL; end
          else if (acc) begin
            if (m_acks + 1 == DISP_SEC) begin nph = P_COOL; m_done = 1; end
            else m_acks++;
          end
        end
        P_COOL: if (acc) begin
          if (m_acks + 1 == COOL_SEC) nph = P_REL;
          else m_acks++;
        end
        default: if (!hand_det) nph = P_IDLE;
      endcase
      if (nph != m_ph) begin m_ph = nph; m_age = 0; m_acks = 0; end
      else m_age++;
    end
  end

  // per-dose statistics and per-cycle comparison
  int det_len = 0, pump_len = 0, cool_len = 0, dose_cnt = 0;
  bit seen_pump = 0, prev_busy = 0;

  initial forever begin
    @(negedge clk);
    begin
      automatic int exp_sec = (m_ph == P_DISP) ? DISP_SEC - m_acks :
                              (m_ph == P_COOL) ? COOL_SEC - m_acks : 0;
      check("count_req", count_req, int'(m_timed(m_ph) && m_age > 0));
      check("pump_en", pump_en, int'(m_ph == P_DISP));
      check("busy", busy, int'(m_ph != P_IDLE));
      check("empty_alarm", empty_alarm, int'(m_alarm));
      check("dose_done", dose_done, int'(m_done));
      check("sec_left", int'(sec_left), exp_sec);
    end
    if (busy && !prev_busy) begin
      det_len = 0; pump_len = 0; cool_len = 0; seen_pump = 0;
    end
    if (pump_en) begin pump_len++; seen_pump = 1; end
    if (busy && !seen_pump && sec_left == 0) det_len++;
    if (busy && !pump_en && sec_left != 0) cool_len++;
    if (dose_done) dose_cnt++;
    prev_busy = busy;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_pump();
    int k;
    for (k = 0; k < 100 && !pump_en; k++) cyc(1);
    check("pump_rise_timeout", int'(pump_en), 1);
  endtask

  initial begin
    cyc(2);
    check("rst_busy", busy, 0);
    check("rst_sec_left", int'(sec_left), 0);
    rst_n = 1'b1;

    // normal dose with held hand
    hand_det = 1'b1;
    cyc(80);
    check("n_det_len", det_len, 12);
    check("n_pump_len", pump_len, 34);
    check("n_cool_len", cool_len, 23);
    check("n_dose_cnt", dose_cnt, 1);
    check("n_release_busy", busy, 1);
    hand_det = 1'b0;
    cyc(2);
    check("n_idle", busy, 0);

    // early removal
    hand_det = 1'b1;
    cyc(5);
    hand_det = 1'b0;
    cyc(3);
    check("e_pump_len", pump_len, 0);
    check("e_req", count_req, 0);
    check("e_busy", busy, 0);

    // tank empties during second dose second
    hand_det = 1'b1;
    wait_pump();
    cyc(16);
    level_ok = 1'b0;
    cyc(1);
    check("t_pump_off", pump_en, 0);
    check("t_alarm", empty_alarm, 1);
    cyc(30);
    check("t_cool_len", cool_len, 23);
    check("t_dose_cnt", dose_cnt, 1);
    hand_det = 1'b0;
    cyc(2);
    hand_det = 1'b1;
    cyc(5);
    check("t_refuse_empty", busy, 0);
    level_ok = 1'b1;
    cyc(5);
    check("t_refuse_hand", busy, 0);
    check("t_alarm_held", empty_alarm, 1);
    hand_det = 1'b0;
    cyc(2);
    check("t_alarm_clr", empty_alarm, 0);

    // held hand stays in release, re-present gives a new dose
    hand_det = 1'b1;
    cyc(80);
    cyc(40);
    check("h_busy", busy, 1);
    check("h_single", dose_cnt, 2);
    hand_det = 1'b0;
    cyc(2);
    hand_det = 1'b1;
    cyc(75);
    check("h_dose_cnt", dose_cnt, 3);
    check("h_pump_len", pump_len, 34);
    hand_det = 1'b0;
    cyc(3);

    // asynchronous reset mid-dose
    hand_det = 1'b1;
    wait_pump();
    cyc(10);
    #1 rst_n = 1'b0;
    #1;
    check("r_pump_async", pump_en, 0);
    check("r_req_async", count_req, 0);
    check("r_busy", busy, 0);
    check("r_sec", int'(sec_left), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(75);
    check("r_det_len", det_len, 12);
    check("r_pump_len", pump_len, 34);
    check("r_dose_cnt", dose_cnt, 4);
    hand_det = 1'b0;
    cyc(3);

    // level drop coincident with the final dose ack
    hand_det = 1'b1;
    wait_pump();
    cyc(33);
    check("c_final_ack", count_ack, 1);
    check("c_final_sec", int'(sec_left), 1);
    level_ok = 1'b0;
    cyc(1);
    check("c_pump_off", pump_en, 0);
    check("c_alarm", empty_alarm, 1);
    check("c_no_done", dose_done, 0);
    cyc(30);
    check("c_dose_cnt", dose_cnt, 4);
    hand_det = 1'b0;
    level_ok = 1'b1;
    cyc(3);
    check("c_alarm_clr", empty_alarm, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
